// File: rtl/trace_chk_pkg.sv
// Shared types and constants for the writeback trace checker.
// Holds the state/error encodings, the golden entry record and the byte-enable mask helper.
package trace_chk_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } chk_state_e;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
    localparam logic [2:0] ERR_PC        = 3'd2;
    localparam logic [2:0] ERR_WNUM      = 3'd3;
    localparam logic [2:0] ERR_WDATA     = 3'd4;
    localparam logic [2:0] ERR_OVERRUN   = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic        last;
    } trace_entry_t;

    // Expands the per-byte write enables into a 32-bit data compare mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{we[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_trace_checker_if.sv
// Writeback debug trace plus golden-entry push port.
// The master is the trace/golden source; the slave is the checker.
interface wb_trace_checker_if;

    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_pc;
    logic [31:0] exp_wdata;
    logic [4:0]  exp_wnum;
    logic        exp_last;

    modport master (
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        output exp_valid, exp_pc, exp_wdata, exp_wnum, exp_last,
        input  exp_ready
    );

    modport slave (
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        input  exp_valid, exp_pc, exp_wdata, exp_wnum, exp_last,
        output exp_ready
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous circular FIFO of golden trace entries.
// Push and pop in the same cycle are both honoured; there is no write-to-head bypass.
module trace_fifo
    import trace_chk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  trace_entry_t din,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count,
    output trace_entry_t head
);

    trace_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == (AW+1)'(0));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates the head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares each writeback commit against the golden FIFO head, latching the first error.
// Status, snapshot and commit counter are all registered; FAIL is absorbing until reset.
module wb_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_trace_checker_if.slave      bus,
    output logic [1:0]             chk_state,
    output logic [2:0]             err_code,
    output logic [31:0]            err_pc,
    output logic [31:0]            err_exp_wdata,
    output logic [31:0]            err_act_wdata,
    output logic [4:0]             err_wnum,
    output logic [CNT_W-1:0]       commit_cnt,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);

    chk_state_e   state_q, state_d;
    logic [2:0]   err_code_q, err_code_d;
    logic [31:0]  err_pc_q, err_pc_d;
    logic [31:0]  err_exp_wdata_q, err_exp_wdata_d;
    logic [31:0]  err_act_wdata_q, err_act_wdata_d;
    logic [4:0]   err_wnum_q, err_wnum_d;
    logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;

    logic         commit_s, push_s, pop_s, full_s, empty_s;
    logic [2:0]   code_s;
    logic [31:0]  mask_s;
    trace_entry_t head_s, din_s;

    assign commit_s      = (bus.debug_wb_rf_we != 4'd0) && (bus.debug_wb_rf_wnum != 5'd0);
    assign bus.exp_ready = (state_q == ST_RUN) && !full_s;
    assign push_s        = bus.exp_valid && bus.exp_ready;
    assign din_s         = '{pc: bus.exp_pc, wnum: bus.exp_wnum, wdata: bus.exp_wdata, last: bus.exp_last};

    trace_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (din_s),
        .full  (full_s),
        .empty (empty_s),
        .count (fifo_count),
        .head  (head_s)
    );

    // Prioritised compare of the current commit against the FIFO head.
    always_comb begin
        mask_s = byte_mask(bus.debug_wb_rf_we);
        if (empty_s) begin
            code_s = ERR_UNDERFLOW;
        end else if (bus.debug_wb_pc != head_s.pc) begin
            code_s = ERR_PC;
        end else if (bus.debug_wb_rf_wnum != head_s.wnum) begin
            code_s = ERR_WNUM;
        end else if (((bus.debug_wb_rf_wdata ^ head_s.wdata) & mask_s) != 32'd0) begin
            code_s = ERR_WDATA;
        end else begin
            code_s = ERR_NONE;
        end
    end

    // Checker state machine, error snapshot and saturating commit counter.
    always_comb begin
        state_d         = state_q;
        err_code_d      = err_code_q;
        err_pc_d        = err_pc_q;
        err_exp_wdata_d = err_exp_wdata_q;
        err_act_wdata_d = err_act_wdata_q;
        err_wnum_d      = err_wnum_q;
        commit_cnt_d    = commit_cnt_q;
        pop_s           = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (commit_s && (code_s == ERR_NONE)) begin
                    pop_s        = 1'b1;
                    commit_cnt_d = (commit_cnt_q == {CNT_W{1'b1}}) ? commit_cnt_q
                                                                   : commit_cnt_q + CNT_W'(1);
                    state_d      = head_s.last ? ST_PASS : ST_RUN;
                end else if (commit_s) begin
                    state_d         = ST_FAIL;
                    err_code_d      = code_s;
                    err_pc_d        = bus.debug_wb_pc;
                    err_exp_wdata_d = empty_s ? 32'd0 : head_s.wdata;
                    err_act_wdata_d = bus.debug_wb_rf_wdata;
                    err_wnum_d      = bus.debug_wb_rf_wnum;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PASS: begin
                if (commit_s) begin
                    state_d         = ST_FAIL;
                    err_code_d      = ERR_OVERRUN;
                    err_pc_d        = bus.debug_wb_pc;
                    err_exp_wdata_d = 32'd0;
                    err_act_wdata_d = bus.debug_wb_rf_wdata;
                    err_wnum_d      = bus.debug_wb_rf_wnum;
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_FAIL;
        endcase
    end

    // Status and snapshot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            err_code_q      <= ERR_NONE;
            err_pc_q        <= 32'd0;
            err_exp_wdata_q <= 32'd0;
            err_act_wdata_q <= 32'd0;
            err_wnum_q      <= 5'd0;
            commit_cnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            err_code_q      <= err_code_d;
            err_pc_q        <= err_pc_d;
            err_exp_wdata_q <= err_exp_wdata_d;
            err_act_wdata_q <= err_act_wdata_d;
            err_wnum_q      <= err_wnum_d;
            commit_cnt_q    <= commit_cnt_d;
        end
    end

    assign chk_state     = state_q;
    assign err_code      = err_code_q;
    assign err_pc        = err_pc_q;
    assign err_exp_wdata = err_exp_wdata_q;
    assign err_act_wdata = err_act_wdata_q;
    assign err_wnum      = err_wnum_q;
    assign commit_cnt    = commit_cnt_q;

endmodule
